relu_maxpool: RTL and testbench



---
 rtl/conv_pkg.sv | 26 ++
 rtl/pool_addr_gen.sv | 23 ++
 rtl/relu_maxpool.sv | 189 ++++++++++++++++++
 tb/tb_relu_maxpool.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution / pooling pipeline:
// data format, pipeline state encoding and default image dimensions.
package conv_pkg;

    localparam int DATA_W = 32;      // Q16.16 word
    localparam int FRAC_W = 16;

    // Default image dimensions through the pipeline
    localparam int CONV_IN_W  = 28;  // image fed to the convolution
    localparam int CONV_OUT_W = 26;  // convolution output / pooling input
    localparam int POOL_OUT_W = 13;  // pooled output

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    // Clamp negative two's-complement values to zero
    function automatic logic [DATA_W-1:0] relu_fn(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Word index of sample k inside the 2x2 pooling window of output (r, c):
// (2r + k[1]) * IN_W + 2c + k[0].
module pool_addr_gen #(
    parameter int IN_W = 26,
    parameter int CW   = 4
) (
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] c,
    input  logic [1:0]    k,
    output logic [31:0]   idx
);

    logic [31:0] row;
    logic [31:0] col;

    // Row/column of the window sample, then raster index
    always_comb begin
        row = (32'(r) << 1) | 32'(k[1]);
        col = (32'(c) << 1) | 32'(k[0]);
        idx = row * 32'(IN_W) + col;
    end

endmodule

// File: rtl/relu_maxpool.sv
// 2x2 stride-2 max pooling (with optional ReLU) of an IN_W x IN_W Q16.16
// map read from M1, written as an (IN_W/2)^2 map to M2.
// Each output: 4 read cycles, 1 wait cycle for the last read, 1 write cycle.
// Build option: define RELU_EN to clamp negative pooled values to zero.
module relu_maxpool
    import conv_pkg::*;
#(
    parameter int          IN_W     = CONV_OUT_W,
    parameter logic [31:0] IN_BASE  = 32'd0,
    parameter logic [31:0] OUT_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    output logic        M1_R_req,
    output logic [31:0] M1_addr,
    input  logic [31:0] M1_R_data,
    output logic [3:0]  M1_W_req,
    output logic [31:0] M1_W_data,
    output logic        M2_R_req,
    output logic [31:0] M2_addr,
    input  logic [31:0] M2_R_data,
    output logic [3:0]  M2_W_req,
    output logic [31:0] M2_W_data
);

    localparam int OUT_W = IN_W / 2;
    localparam int NOUT  = OUT_W * OUT_W;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OW    = (NOUT > 1) ? $clog2(NOUT) : 1;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [CW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    logic [OW-1:0]       o_q, o_d;

    // Read-data tracking: a request issued in cycle t returns data in t+1
    logic                dv_q, dv_d;
    logic [1:0]          dk_q, dk_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   sample_max;
    logic [DATA_W-1:0]   pooled;

    // Registered outputs
    logic                finish_q, finish_d;
    logic                m1_req_q, m1_req_d;
    logic [31:0]         m1_addr_q, m1_addr_d;
    logic                m2_we_q, m2_we_d;
    logic [31:0]         m2_addr_q, m2_addr_d;
    logic [DATA_W-1:0]   m2_data_q, m2_data_d;

    logic [31:0]         idx_d;
    logic                unused_m2_rdata;

    assign unused_m2_rdata = ^M2_R_data;

    // Address of the read that will be issued in the next cycle
    pool_addr_gen #(
        .IN_W (IN_W),
        .CW   (CW)
    ) u_addr_gen (
        .r   (r_d),
        .c   (c_d),
        .k   (k_d),
        .idx (idx_d)
    );

    // Next state and window / output counters
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        o_d     = o_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD;
                    k_d     = 2'd0;
                    r_d     = '0;
                    c_d     = '0;
                    o_d     = '0;
                end
            end
            RD: begin
                if (k_q == 2'd3) begin
                    state_d = WAIT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            WAIT: begin
                state_d = WR;
            end
            WR: begin
                if (o_q == OW'(NOUT - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                    k_d     = 2'd0;
                    o_d     = o_q + OW'(1);
                    if (c_q == CW'(OUT_W - 1)) begin
                        c_d = '0;
                        r_d = r_q + CW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Running max over the window; ties keep the held value
    always_comb begin
        sample_max = max_q;
        if (dk_q == 2'd0 || $signed(M1_R_data) > $signed(max_q)) begin
            sample_max = M1_R_data;
        end
`ifdef RELU_EN
        pooled = relu_fn(sample_max);
`else
        pooled = sample_max;
`endif
    end

    // Next values of the registered memory-port outputs
    always_comb begin
        dv_d      = (state_q == RD);
        dk_d      = k_q;
        max_d     = dv_q ? sample_max : max_q;
        m2_data_d = (dv_q && dk_q == 2'd3) ? pooled : m2_data_q;
        finish_d  = (state_d == DONE);
        m1_req_d  = (state_d == RD);
        m1_addr_d = m1_req_d ? (IN_BASE + (idx_d << 2)) : m1_addr_q;
        m2_we_d   = (state_d == WR);
        m2_addr_d = m2_we_d ? (OUT_BASE + (32'(o_d) << 2)) : m2_addr_q;
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            o_q       <= '0;
            dv_q      <= 1'b0;
            dk_q      <= '0;
            max_q     <= '0;
            finish_q  <= 1'b0;
            m1_req_q  <= 1'b0;
            m1_addr_q <= '0;
            m2_we_q   <= 1'b0;
            m2_addr_q <= '0;
            m2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            r_q       <= r_d;
            c_q       <= c_d;
            o_q       <= o_d;
            dv_q      <= dv_d;
            dk_q      <= dk_d;
            max_q     <= max_d;
            finish_q  <= finish_d;
            m1_req_q  <= m1_req_d;
            m1_addr_q <= m1_addr_d;
            m2_we_q   <= m2_we_d;
            m2_addr_q <= m2_addr_d;
            m2_data_q <= m2_data_d;
        end
    end

    assign finish    = finish_q;
    assign M1_R_req  = m1_req_q;
    assign M1_addr   = m1_addr_q;
    assign M1_W_req  = 4'b0000;
    assign M1_W_data = '0;
    assign M2_R_req  = 1'b0;
    assign M2_addr   = m2_addr_q;
    assign M2_W_req  = {4{m2_we_q}};
    assign M2_W_data = m2_data_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: memory models on M1/M2, a vector table of
// pooled values per input pattern, timing checks per pass, plus restart and
// mid-run reset sequences. Expectations follow the RELU_EN build option.
module tb_relu_maxpool;

    localparam int          IN_W     = 26;
    localparam int          NIN      = IN_W * IN_W;
    localparam int          NOUT     = (IN_W / 2) * (IN_W / 2);
    localparam logic [31:0] IN_BASE  = 32'h0000_0400;
    localparam logic [31:0] OUT_BASE = 32'h0001_0000;

`ifdef RELU_EN
    localparam logic [31:0] NEG1 = 32'h0000_0000;
    localparam logic [31:0] NEG2 = 32'h0000_0000;
`else
    localparam logic [31:0] NEG1 = 32'hFFFF_0000;
    localparam logic [31:0] NEG2 = 32'hFFFE_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finish;
    logic        M1_R_req;
    logic [31:0] M1_addr;
    logic [31:0] M1_R_data;
    logic [3:0]  M1_W_req;
    logic [31:0] M1_W_data;
    logic        M2_R_req;
    logic [31:0] M2_addr;
    logic [31:0] M2_R_data = 32'h0;
    logic [3:0]  M2_W_req;
    logic [31:0] M2_W_data;

    relu_maxpool #(
        .IN_W     (IN_W),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .M1_R_req  (M1_R_req),
        .M1_addr   (M1_addr),
        .M1_R_data (M1_R_data),
        .M1_W_req  (M1_W_req),
        .M1_W_data (M1_W_data),
        .M2_R_req  (M2_R_req),
        .M2_addr   (M2_addr),
        .M2_R_data (M2_R_data),
        .M2_W_req  (M2_W_req),
        .M2_W_data (M2_W_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [0:NIN-1];
    logic [31:0] outmem [0:NOUT-1];

    int n_cmp = 0;
    int n_bad = 0;

    // Pass bookkeeping: e0/pass_id written by the stimulus, the rest by the monitor
    int ncyc = 0;
    int e0 = 0;
    int pass_id = 0;
    int seen_pass = 0;
    int first_rd = -1;
    int first_wr = -1;
    int first_wr_idx = -1;
    int last_wr_idx = -1;
    int fin_cyc = -1;
    int wr_cnt = 0;
    int wr_total = 0;
    int bad = 0;

    // M1 source memory: one-cycle read latency
    always @(posedge clk) begin
        logic [31:0] a;
        if (M1_R_req) begin
            a = (M1_addr - IN_BASE) >> 2;
            M1_R_data <= (a < NIN) ? mem[a] : 32'hBAD0_BAD0;
        end else begin
            M1_R_data <= 32'h5A5A_5A5A;
        end
    end

    // Monitor: samples cycle activity mid-cycle and captures M2 writes
    always @(negedge clk) begin
        int widx;
        int rel;
        ncyc = ncyc + 1;
        if (seen_pass != pass_id) begin
            seen_pass    = pass_id;
            first_rd     = -1;
            first_wr     = -1;
            first_wr_idx = -1;
            last_wr_idx  = -1;
            fin_cyc      = -1;
            wr_cnt       = 0;
            bad          = 0;
            for (int i = 0; i < NOUT; i++) outmem[i] = 32'hDEAD_BEEF;
        end
        if (M1_R_req) begin
            if (first_rd < 0) first_rd = ncyc;
            if (M1_addr < IN_BASE || M1_addr[1:0] != 2'b00 ||
                ((M1_addr - IN_BASE) >> 2) >= NIN) bad++;
        end
        if (M2_W_req != 4'h0) begin
            widx = int'((M2_addr - OUT_BASE) >> 2);
            wr_cnt++;
            wr_total++;
            if (first_wr < 0) begin
                first_wr     = ncyc;
                first_wr_idx = widx;
            end
            last_wr_idx = widx;
            rel = ncyc - e0 - 5;
            if (M2_W_req != 4'hF || M2_addr[1:0] != 2'b00 || widx < 0 || widx >= NOUT ||
                rel < 0 || (rel % 6) != 0 || (rel / 6) != widx) bad++;
            else outmem[widx] = M2_W_data;
        end
        if (finish && fin_cyc < 0) fin_cyc = ncyc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic load_pattern(input int p);
        for (int i = 0; i < NIN; i++) begin
            mem[i] = (p == 0) ? (32'(i) << 16) : ((p == 1) ? 32'hFFFF_0000 : 32'h0);
        end
        case (p)
            2: begin
                mem[0] = 32'hFFFB_0000; mem[1] = 32'h0003_0000;
                mem[26] = 32'h0002_0000; mem[27] = 32'hFFFF_0000;
            end
            3: begin
                mem[0] = 32'h0007_0000; mem[1] = 32'h0007_0000;
                mem[26] = 32'h0007_0000; mem[27] = 32'h0007_0000;
            end
            4: begin
                mem[0] = 32'hFFFD_0000; mem[1] = 32'hFFFE_0000;
                mem[26] = 32'hFFF9_0000; mem[27] = 32'hFFFC_0000;
                mem[2] = 32'h8000_0000; mem[3] = 32'h7FFF_FFFF;
                mem[28] = 32'h0000_0001; mem[29] = 32'h0000_0000;
                mem[4] = 32'h0001_0000; mem[5] = 32'h0002_0000;
                mem[30] = 32'h0005_0000; mem[31] = 32'h0003_0000;
                mem[648] = 32'h0001_0000; mem[649] = 32'h0002_0000;
                mem[674] = 32'h0003_0000; mem[675] = 32'h0009_0000;
            end
            default: ;
        endcase
    endtask

    task automatic begin_pass();
        @(negedge clk);
        #1;
        start   = 1'b1;
        pass_id = pass_id + 1;
        e0      = ncyc + 1;
    endtask

    task automatic run_pass(input int hold, input string tag);
        begin_pass();
        @(negedge clk);
        #1;
        chk({tag, "_finish_drop"}, 32'(finish), 32'd0);
        repeat (hold) @(negedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 1200 && fin_cyc < 0; j++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, "_done"}, 32'(fin_cyc >= 0), 32'd1);
        chk({tag, "_first_rd"}, 32'(first_rd - e0), 32'd0);
        chk({tag, "_first_wr"}, 32'(first_wr - e0), 32'd5);
        chk({tag, "_first_wr_o"}, 32'(first_wr_idx), 32'd0);
        chk({tag, "_finish_cyc"}, 32'(fin_cyc - e0), 32'd1014);
        chk({tag, "_wr_count"}, 32'(wr_cnt), 32'd169);
        chk({tag, "_protocol"}, 32'(bad), 32'd0);
        if (fin_cyc < 0) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic check_ramp(input string tag);
        int nb = 0;
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < 13; c++) begin
                if (outmem[r * 13 + c] !== (32'((2 * r + 1) * 26 + 2 * c + 1) << 16)) nb++;
            end
        end
        chk({tag, "_ramp_map_errors"}, 32'(nb), 32'd0);
    endtask

    task automatic check_const(input string tag, input logic [31:0] v);
        int nb = 0;
        for (int o = 0; o < NOUT; o++) begin
            if (outmem[o] !== v) nb++;
        end
        chk({tag, "_const_map_errors"}, 32'(nb), 32'd0);
    endtask

    typedef struct {
        int          pat;
        int          o;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cur;
        int wr_at_rst;

        vecs[0]  = '{0, 0,   32'h001B_0000, "ramp_o0"};
        vecs[1]  = '{0, 14,  32'h0051_0000, "ramp_o14"};
        vecs[2]  = '{0, 168, 32'h02A3_0000, "ramp_o168"};
        vecs[3]  = '{1, 0,   NEG1,          "neg1_o0"};
        vecs[4]  = '{1, 84,  NEG1,          "neg1_o84"};
        vecs[5]  = '{1, 168, NEG1,          "neg1_o168"};
        vecs[6]  = '{2, 0,   32'h0003_0000, "mixed_o0"};
        vecs[7]  = '{2, 1,   32'h0000_0000, "mixed_o1"};
        vecs[8]  = '{3, 0,   32'h0007_0000, "tie_o0"};
        vecs[9]  = '{4, 0,   NEG2,          "allneg_o0"};
        vecs[10] = '{4, 1,   32'h7FFF_FFFF, "signed_o1"};
        vecs[11] = '{4, 2,   32'h0005_0000, "k2max_o2"};
        vecs[12] = '{4, 168, 32'h0009_0000, "k3max_o168"};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_m1_req", 32'(M1_R_req), 32'd0);
        chk("rst_m1_addr", M1_addr, 32'd0);
        chk("rst_m1_wreq", 32'(M1_W_req), 32'd0);
        chk("rst_m1_wdata", M1_W_data, 32'd0);
        chk("rst_m2_rreq", 32'(M2_R_req), 32'd0);
        chk("rst_m2_addr", M2_addr, 32'd0);
        chk("rst_m2_wreq", 32'(M2_W_req), 32'd0);
        chk("rst_m2_wdata", M2_W_data, 32'd0);
        rst = 1'b0;

        // Table of pooled values, one full pass per input pattern
        cur = -1;
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].pat != cur) begin
                cur = vecs[v].pat;
                load_pattern(cur);
                run_pass(0, $sformatf("pat%0d", cur));
                if (cur == 0) check_ramp("pat0");
                if (cur == 1) check_const("pat1", NEG1);
            end
            chk(vecs[v].name, outmem[vecs[v].o], vecs[v].exp);
        end

        // start held through RD/WAIT/WR is ignored; fresh start from DONE restarts at o=0
        chk("done_finish_high", 32'(finish), 32'd1);
        load_pattern(0);
        run_pass(10, "hold");
        check_ramp("hold");
        run_pass(0, "restart");
        check_ramp("restart");

        // Asynchronous reset during the write of o=50
        begin_pass();
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 400 && last_wr_idx != 50; j++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_reached_o50", 32'(last_wr_idx), 32'd50);
        rst = 1'b1;
        #1;
        chk("arst_m2_wreq", 32'(M2_W_req), 32'd0);
        chk("arst_m1_req", 32'(M1_R_req), 32'd0);
        chk("arst_m2_addr", M2_addr, 32'd0);
        chk("arst_m1_addr", M1_addr, 32'd0);
        chk("arst_m2_wdata", M2_W_data, 32'd0);
        chk("arst_finish", 32'(finish), 32'd0);
        wr_at_rst = wr_total;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("post_rst_no_writes", 32'(wr_total - wr_at_rst), 32'd0);
        chk("post_rst_idle_req", 32'(M1_R_req), 32'd0);
        run_pass(0, "after_rst");
        check_ramp("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
